mem_stall_ctrl: RTL and testbench
=================================

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: maximum BUSY cycles without mem_ack before error; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-004 The block SHALL have port Addr, input, 16: byte address from the memory stage.
REQ-005 The block SHALL have port DataIn, input, 16: store data.
REQ-006 The block SHALL have port Rd, input, 1: load request.
REQ-007 The block SHALL have port Wr, input, 1: store request.
REQ-008 The block SHALL have port Halt, input, 1: halt has reached the memory stage.
REQ-009 The block SHALL have port Stall, output, 1: freeze all pipeline registers this cycle.
REQ-010 The block SHALL have port Done, output, 1: access completes this cycle.
REQ-011 The block SHALL have port DataOut, output, 16: load result, valid while Done=1.
REQ-012 The block SHALL have port Err, output, 1: sticky error flag.
REQ-013 The block SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 16) and mem_wdata (out, 16): request to the multi-cycle backing memory.
REQ-014 The block SHALL have ports mem_ack (in, 1) and mem_rdata (in, 16): memory completion, with read data valid during the ack cycle.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, BUSY and DONE, state-encoded in 2 bits; the unused encoding SHALL go to IDLE.
REQ-016 A valid request SHALL be Rd XOR Wr, with Addr[0]=0, Halt=0 and Err=0, while in IDLE.
REQ-017 An invalid request (Rd&Wr, or Addr[0]=1 with Rd|Wr) in IDLE SHALL set Err at the next edge, issue no memory access, leave Stall=0 and keep the FSM in IDLE.
REQ-018 The block SHALL hold a one-entry read buffer: buf_valid, buf_addr[15:0], buf_data[15:0].
REQ-019 A valid read in IDLE that hits the buffer (buf_valid && buf_addr==Addr) SHALL give, combinationally in the same cycle, Done=1, DataOut=buf_data, Stall=0, and the FSM SHALL stay in IDLE.
REQ-020 A valid read miss, or any valid write, in IDLE SHALL assert Stall=1 combinationally in the same cycle, latch Addr, DataIn and Wr into request registers, clear the timeout counter, and move to BUSY.
REQ-021 In BUSY the block SHALL drive mem_req=1, mem_addr, mem_wdata and mem_we from the request registers, and Stall=1; Rd, Wr, Addr and DataIn SHALL be ignored.
REQ-022 In BUSY with mem_ack=1 on a read, the block SHALL capture mem_rdata into the DataOut register and the buffer (buf_valid=1, buf_addr=latched address), then move to DONE.
REQ-023 In BUSY with mem_ack=1 on a write, if buf_valid and buf_addr equals the latched address, buf_data SHALL be updated to the latched data; the block SHALL then move to DONE.
REQ-024 In DONE the block SHALL drive Done=1, Stall=0 and DataOut from the register, SHALL ignore Rd and Wr (no re-issue of the instruction still presented), and SHALL move to IDLE at the next edge.
REQ-025 Read-to-done latency SHALL be 0 cycles on a hit; on a miss it SHALL be ack cycle + 1, i.e. Done asserts in the cycle after mem_ack.
REQ-026 Each BUSY cycle without ack SHALL increment an 8-bit counter; when the counter equals TIMEOUT-1 and mem_ack=0, the block SHALL set Err, drop mem_req at the next edge, and move to IDLE without Done.
REQ-027 mem_ack arriving in the same cycle the timeout condition is met SHALL be treated as success (ack wins).
REQ-028 mem_ack while not in BUSY SHALL be ignored.
REQ-029 When Halt=1 in IDLE, new requests SHALL be refused (no Stall, no access); Halt arriving in BUSY SHALL NOT abort the access in flight.
REQ-030 Outputs when not stated otherwise SHALL be: Done=0, Stall=0, mem_req=0, mem_we=0; DataOut SHALL hold its last value.

Reset
REQ-031 With rst=0 at a clock edge, the block SHALL go to IDLE and clear buf_valid, Err, the counter, all request registers and DataOut to 0.
REQ-032 Reset asserted mid-operation (BUSY or DONE) SHALL abandon the access: mem_req=0 from the next cycle, and no Done.
REQ-033 Outputs during reset cycles SHALL be Stall=0, Done=0, mem_req=0.

Verification
REQ-034 Read Addr=0x0010 with ack after 3 BUSY cycles and mem_rdata=0xBEEF SHALL give Stall=1 for 4 cycles (IDLE + 3 BUSY), then Done=1 with DataOut=0xBEEF; a repeat read of 0x0010 SHALL give Done=1 the same cycle with DataOut=0xBEEF and Stall=0.
REQ-035 Write 0x1234 to 0x0010 after that buffer fill SHALL give mem_we=1, mem_wdata=0x1234, then Done=1; the next read of 0x0010 SHALL hit with DataOut=0x1234 and mem_req=0.
REQ-036 Read Addr=0x0011, and separately Rd=Wr=1, SHALL set Err=1 with mem_req never asserted and Stall=0.
REQ-037 With TIMEOUT=4 and mem_ack held 0, the block SHALL give mem_req=1 for exactly 4 cycles, then Err=1, return to IDLE and never assert Done; with mem_ack=1 in the 4th BUSY cycle it SHALL give Done=1 and Err=0.
REQ-038 rst=0 on the 2nd BUSY cycle SHALL give mem_req=0 and Stall=0 next cycle, and a following read of the previously buffered address SHALL miss.
REQ-039 Halt=1 with Rd=1 in IDLE SHALL give no Stall, no Done and no mem_req.

Source files
------------

// File: rtl/mem_stall_ctrl_if.sv
// Memory-stage request/response and backing-memory signals of mem_stall_ctrl.
// master: pipeline plus backing memory; slave: the stall controller.
interface mem_stall_ctrl_if;
   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic        Rd;
   logic        Wr;
   logic        Halt;
   logic        Stall;
   logic        Done;
   logic [15:0] DataOut;
   logic        Err;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;

   modport master (
      output Addr, DataIn, Rd, Wr, Halt, mem_ack, mem_rdata,
      input  Stall, Done, DataOut, Err, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  Addr, DataIn, Rd, Wr, Halt, mem_ack, mem_rdata,
      output Stall, Done, DataOut, Err, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_stall_ctrl.sv
// Pipeline stall controller for a multi-cycle memory, with a one-entry read buffer,
// a BUSY timeout and a sticky error flag for malformed requests.
module mem_stall_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input logic             clk,
   input logic             rst,
   mem_stall_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StBusy = 2'b01,
      StDone = 2'b10
   } state_e;

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   state_e      state_q;
   logic        err_q;
   logic [7:0]  cnt_q;
   logic [15:0] req_addr_q;
   logic [15:0] req_wdata_q;
   logic        req_we_q;
   logic [15:0] dout_q;
   logic        buf_valid_q;
   logic [15:0] buf_addr_q;
   logic [15:0] buf_data_q;

   logic bad_req;
   logic valid_req;
   logic hit;
   logic start;

   assign bad_req   = (bus.Rd & bus.Wr) | (bus.Addr[0] & (bus.Rd | bus.Wr));
   assign valid_req = (bus.Rd ^ bus.Wr) & ~bus.Addr[0] & ~bus.Halt & ~err_q;
   assign hit       = valid_req & bus.Rd & buf_valid_q & (buf_addr_q == bus.Addr);
   assign start     = valid_req & ~hit;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         err_q       <= 1'b0;
         cnt_q       <= 8'd0;
         req_addr_q  <= 16'h0000;
         req_wdata_q <= 16'h0000;
         req_we_q    <= 1'b0;
         dout_q      <= 16'h0000;
         buf_valid_q <= 1'b0;
         buf_addr_q  <= 16'h0000;
         buf_data_q  <= 16'h0000;
      end else begin
         case (state_q)
            StIdle: begin
               if (bad_req) begin
                  err_q <= 1'b1;
               end else if (start) begin
                  req_addr_q  <= bus.Addr;
                  req_wdata_q <= bus.DataIn;
                  req_we_q    <= bus.Wr;
                  cnt_q       <= 8'd0;
                  state_q     <= StBusy;
               end
            end
            StBusy: begin
               // An ack in the timeout cycle still counts as success.
               if (bus.mem_ack) begin
                  if (!req_we_q) begin
                     dout_q      <= bus.mem_rdata;
                     buf_valid_q <= 1'b1;
                     buf_addr_q  <= req_addr_q;
                     buf_data_q  <= bus.mem_rdata;
                  end else if (buf_valid_q && buf_addr_q == req_addr_q) begin
                     buf_data_q <= req_wdata_q;
                  end
                  state_q <= StDone;
               end else if (cnt_q == TimeoutLast) begin
                  err_q   <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.Err       = err_q;
   assign bus.mem_addr  = req_addr_q;
   assign bus.mem_wdata = req_wdata_q;

   // Outputs are forced quiet while reset is held, whatever state is still registered.
   always_comb begin
      bus.Stall   = 1'b0;
      bus.Done    = 1'b0;
      bus.DataOut = dout_q;
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      if (rst) begin
         case (state_q)
            StIdle: begin
               if (hit) begin
                  bus.Done    = 1'b1;
                  bus.DataOut = buf_data_q;
               end else if (start) begin
                  bus.Stall = 1'b1;
               end
            end
            StBusy: begin
               bus.Stall   = 1'b1;
               bus.mem_req = 1'b1;
               bus.mem_we  = req_we_q;
            end
            StDone:  bus.Done = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Cycle-by-cycle vector bench for mem_stall_ctrl (TIMEOUT=4) with a scoreboard queue,
// plus a bounded timeout sequence.
module tb_mem_stall_ctrl;

   logic clk = 1'b0;
   logic rst;

   mem_stall_ctrl_if bus ();

   mem_stall_ctrl #(.TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // DataOut shown only while Done, mem_addr while mem_req, mem_wdata on write requests.
   typedef struct packed {
      logic        stall;
      logic        done;
      logic        err;
      logic        req;
      logic        we;
      logic [15:0] dout;
      logic [15:0] maddr;
      logic [15:0] mwdata;
   } obs_t;

   typedef struct {
      string       tag;
      logic [3:0]  ctl;   // {rst, Rd, Wr, Halt}
      logic [15:0] addr;
      logic [15:0] din;
      logic        ack;
      logic [15:0] rdata;
      obs_t        exp;
   } vec_t;

   vec_t vecs[$];
   obs_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add(input string tag, input logic [3:0] ctl, input logic [15:0] addr,
                      input logic [15:0] din, input logic ack, input logic [15:0] rdata,
                      input logic [4:0] flags, input logic [15:0] dout,
                      input logic [15:0] maddr, input logic [15:0] mwdata);
      vec_t v;
      v.tag   = tag;
      v.ctl   = ctl;
      v.addr  = addr;
      v.din   = din;
      v.ack   = ack;
      v.rdata = rdata;
      v.exp   = {flags, dout, maddr, mwdata};
      vecs.push_back(v);
   endtask

   function automatic obs_t observe();
      obs_t o;
      o.stall  = bus.Stall;
      o.done   = bus.Done;
      o.err    = bus.Err;
      o.req    = bus.mem_req;
      o.we     = bus.mem_we;
      o.dout   = bus.Done ? bus.DataOut : 16'h0000;
      o.maddr  = bus.mem_req ? bus.mem_addr : 16'h0000;
      o.mwdata = (bus.mem_req && bus.mem_we) ? bus.mem_wdata : 16'h0000;
      return o;
   endfunction

   task automatic check_obs(input string tag);
      obs_t a;
      obs_t e;
      a = observe();
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got stall=%b done=%b err=%b req=%b we=%b dout=%h maddr=%h wdata=%h, want stall=%b done=%b err=%b req=%b we=%b dout=%h maddr=%h wdata=%h",
                  tag, a.stall, a.done, a.err, a.req, a.we, a.dout, a.maddr, a.mwdata,
                  e.stall, e.done, e.err, e.req, e.we, e.dout, e.maddr, e.mwdata);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   task automatic drive(input logic [3:0] ctl, input logic [15:0] addr, input logic [15:0] din,
                        input logic ack, input logic [15:0] rdata);
      rst           = ctl[3];
      bus.Rd        = ctl[2];
      bus.Wr        = ctl[1];
      bus.Halt      = ctl[0];
      bus.Addr      = addr;
      bus.DataIn    = din;
      bus.mem_ack   = ack;
      bus.mem_rdata = rdata;
   endtask

   task automatic apply(input vec_t v);
      @(posedge clk);
      #1;
      drive(v.ctl, v.addr, v.din, v.ack, v.rdata);
      exp_q.push_back(v.exp);
      @(negedge clk);
      check_obs(v.tag);
   endtask

   initial begin
      int n_req;
      int n_done;
      int seen;

      drive(4'b0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      repeat (2) @(posedge clk);

      // flags = {Stall, Done, Err, mem_req, mem_we}
      add("rst_gated",   4'b0100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
      add("rst_idle",    4'b0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
      // Read miss, ack in third BUSY cycle, then buffer hit.
      add("rd_miss",     4'b1100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b10000, 16'h0000, 16'h0000, 16'h0000);
      add("rd_busy1",    4'b1100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b10010, 16'h0000, 16'h0010, 16'h0000);
      add("rd_busy2",    4'b1100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b10010, 16'h0000, 16'h0010, 16'h0000);
      add("rd_busy3ack", 4'b1100, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 5'b10010, 16'h0000, 16'h0010, 16'h0000);
      add("rd_done",     4'b1100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b01000, 16'hBEEF, 16'h0000, 16'h0000);
      add("rd_hit",      4'b1100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b01000, 16'hBEEF, 16'h0000, 16'h0000);
      // Write to buffered address updates the buffer.
      add("wr_idle",     4'b1010, 16'h0010, 16'h1234, 1'b0, 16'h0000, 5'b10000, 16'h0000, 16'h0000, 16'h0000);
      add("wr_busy",     4'b1010, 16'h0010, 16'h1234, 1'b0, 16'h0000, 5'b10011, 16'h0000, 16'h0010, 16'h1234);
      add("wr_ack",      4'b1010, 16'h0010, 16'h1234, 1'b1, 16'hDEAD, 5'b10011, 16'h0000, 16'h0010, 16'h1234);
      add("wr_done",     4'b1010, 16'h0010, 16'h1234, 1'b0, 16'h0000, 5'b01000, 16'hBEEF, 16'h0000, 16'h0000);
      add("hit_updated", 4'b1100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b01000, 16'h1234, 16'h0000, 16'h0000);
      // Write elsewhere leaves the buffer alone.
      add("wr2_idle",    4'b1010, 16'h0020, 16'h5555, 1'b0, 16'h0000, 5'b10000, 16'h0000, 16'h0000, 16'h0000);
      add("wr2_ack",     4'b1010, 16'h0020, 16'h5555, 1'b1, 16'h0000, 5'b10011, 16'h0000, 16'h0020, 16'h5555);
      add("wr2_done",    4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b01000, 16'hBEEF, 16'h0000, 16'h0000);
      add("hit_kept",    4'b1100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b01000, 16'h1234, 16'h0000, 16'h0000);
      // Halt refuses in IDLE, not in BUSY.
      add("halt_idle",   4'b1101, 16'h0040, 16'h0000, 1'b0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
      add("rd40_miss",   4'b1100, 16'h0040, 16'h0000, 1'b0, 16'h0000, 5'b10000, 16'h0000, 16'h0000, 16'h0000);
      add("halt_busy",   4'b1101, 16'h0040, 16'h0000, 1'b0, 16'h0000, 5'b10010, 16'h0000, 16'h0040, 16'h0000);
      add("halt_ack",    4'b1101, 16'h0040, 16'h0000, 1'b1, 16'h0A0A, 5'b10010, 16'h0000, 16'h0040, 16'h0000);
      add("rd40_done",   4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b01000, 16'h0A0A, 16'h0000, 16'h0000);
      // Single entry: 0x0010 was evicted.
      add("evict_miss",  4'b1100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b10000, 16'h0000, 16'h0000, 16'h0000);
      add("evict_ack",   4'b1000, 16'h0000, 16'h0000, 1'b1, 16'h1234, 5'b10010, 16'h0000, 16'h0010, 16'h0000);
      add("evict_done",  4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b01000, 16'h1234, 16'h0000, 16'h0000);
      add("stray_ack",   4'b1000, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
      add("hit_stray",   4'b1100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b01000, 16'h1234, 16'h0000, 16'h0000);
      // Reset in second BUSY cycle abandons access and clears the buffer.
      add("rd60_miss",   4'b1100, 16'h0060, 16'h0000, 1'b0, 16'h0000, 5'b10000, 16'h0000, 16'h0000, 16'h0000);
      add("rd60_busy1",  4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10010, 16'h0000, 16'h0060, 16'h0000);
      add("rst_busy2",   4'b0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
      add("after_rst",   4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
      add("buf_cleared", 4'b1100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b10000, 16'h0000, 16'h0000, 16'h0000);
      add("refill_ack",  4'b1000, 16'h0000, 16'h0000, 1'b1, 16'h7777, 5'b10010, 16'h0000, 16'h0010, 16'h0000);
      add("refill_done", 4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b01000, 16'h7777, 16'h0000, 16'h0000);
      // Malformed requests set sticky Err and are refused.
      add("odd_addr",    4'b1100, 16'h0011, 16'h0000, 1'b0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
      add("odd_err",     4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00100, 16'h0000, 16'h0000, 16'h0000);
      add("err_refuse",  4'b1100, 16'h0010, 16'h0000, 1'b0, 16'h0000, 5'b00100, 16'h0000, 16'h0000, 16'h0000);
      add("err_rst",     4'b0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00100, 16'h0000, 16'h0000, 16'h0000);
      add("rdwr",        4'b1110, 16'h0020, 16'h0000, 1'b0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
      add("rdwr_err",    4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00100, 16'h0000, 16'h0000, 16'h0000);
      add("rdwr_rst",    4'b0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00100, 16'h0000, 16'h0000, 16'h0000);
      add("err_clear",   4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
      // Timeout after four BUSY cycles.
      add("to_miss",     4'b1100, 16'h0080, 16'h0000, 1'b0, 16'h0000, 5'b10000, 16'h0000, 16'h0000, 16'h0000);
      add("to_busy1",    4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10010, 16'h0000, 16'h0080, 16'h0000);
      add("to_busy2",    4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10010, 16'h0000, 16'h0080, 16'h0000);
      add("to_busy3",    4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10010, 16'h0000, 16'h0080, 16'h0000);
      add("to_busy4",    4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10010, 16'h0000, 16'h0080, 16'h0000);
      add("to_err",      4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00100, 16'h0000, 16'h0000, 16'h0000);
      add("to_rst",      4'b0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00100, 16'h0000, 16'h0000, 16'h0000);
      add("to_clear",    4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
      // Ack in the timeout cycle wins.
      add("late_miss",   4'b1100, 16'h0080, 16'h0000, 1'b0, 16'h0000, 5'b10000, 16'h0000, 16'h0000, 16'h0000);
      add("late_busy1",  4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10010, 16'h0000, 16'h0080, 16'h0000);
      add("late_busy2",  4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10010, 16'h0000, 16'h0080, 16'h0000);
      add("late_busy3",  4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10010, 16'h0000, 16'h0080, 16'h0000);
      add("late_ack4",   4'b1000, 16'h0000, 16'h0000, 1'b1, 16'h4444, 5'b10010, 16'h0000, 16'h0080, 16'h0000);
      add("late_done",   4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b01000, 16'h4444, 16'h0000, 16'h0000);

      foreach (vecs[i]) apply(vecs[i]);

      // Bounded watch of a timed-out read.
      @(posedge clk);
      #1;
      drive(4'b1100, 16'h0090, 16'h0000, 1'b0, 16'h0000);
      @(posedge clk);
      #1;
      drive(4'b1000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      n_req  = 0;
      n_done = 0;
      seen   = 0;
      for (int i = 0; i < 12 && seen == 0; i++) begin
         @(negedge clk);
         if (bus.mem_req === 1'b1) n_req++;
         if (bus.Done === 1'b1) n_done++;
         if (bus.Err === 1'b1) seen = 1;
      end
      check_int("watch_err_seen", seen, 1);
      check_int("watch_req_cycles", n_req, 4);
      check_int("watch_done_cycles", n_done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
